instr_arbiter: RTL and testbench
================================

# instr_arbiter

Round-robin arbiter that shares the single `instr_packet_s` input of a downstream `block`-style consumer between up to `N_REQ` requesters. Each requester presents a packet with valid/ready; per-lane enables gate eligibility. The winner is captured into a one-entry output register that drives the consumer through a valid/ready handshake. A wrapping counter reports the number of packets issued.

## Interface
- `N_REQ`, default 4: number of requester lanes (2..8).
- `CNT_W`, default 11: width of the issued-packet counter.
- `clk` in 1: sole clock, all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `N_REQ`: lane `i` has a packet on `req_pkt[i]`.
- `req_pkt` in `instr_packet_s [N_REQ-1:0]` (unpacked array, 27 bits each: `instr[16:0]`, `addr[9:0]`): per-lane packet.
- `req_ready` out `N_REQ`: one-hot or zero; lane `i` is accepted this cycle.
- `lane_en` in `N_REQ`: lane eligibility mask; 0 means the lane is never granted.
- `out_valid` out 1: `out_pkt` holds an issued packet.
- `out_pkt` out `instr_packet_s` (27): issued packet.
- `out_src` out `$clog2(N_REQ)`: lane index of `out_pkt`.
- `out_ready` in 1: consumer accepts `out_pkt` when high with `out_valid`.
- `issue_cnt` out `CNT_W`: packets issued since reset, mod 2^`CNT_W`.

## Operation
- `eligible = req_valid & lane_en`.
- `load = !out_valid || out_ready`: the output register is empty or drains this cycle.
- Grant search: start at `last_grant+1` and wrap modulo `N_REQ`; the first eligible lane wins. `req_ready[g] = load && eligible != 0` for winner `g` only. All other `req_ready` bits are 0.
- On grant, registered at posedge:
  - `out_pkt <= req_pkt[g]`, `out_src <= g`, `out_valid <= 1`
  - `last_grant <= g`
  - `issue_cnt <= issue_cnt + 1`, wrapping from 2^`CNT_W`-1 to 0.
- `load` with no eligible lane: `out_valid <= 0`. `out_pkt`, `out_src` and `last_grant` hold their values.
- `!load` (stalled): the output register, `last_grant` and `issue_cnt` are all held, and every `req_ready` bit is 0.
- Effective states: EMPTY (`out_valid=0`) and FULL (`out_valid=1`).
  - EMPTY→FULL on grant.
  - FULL→FULL on drain+grant, or on stall.
  - FULL→EMPTY on drain with no eligible lane.
- Deasserting `lane_en[i]` never affects a packet already in the output register.
- `lane_en` changes take effect in the same cycle's search.
- `req_ready` depends combinationally on `req_valid`, `lane_en` and `out_ready`. `out_valid` and `out_pkt` are purely registered.

## Timing
- Reset values, applied one edge after `rst` is sampled high:
  - `out_valid=0`, `out_pkt=0`, `out_src=0`, `issue_cnt=0`
  - `last_grant=N_REQ-1`, so lane 0 has first priority.
  - `req_ready=0` while `rst` is high.
- Reset mid-operation discards any held packet; no handshake completes in a reset cycle.
- Latency: grant in cycle t gives `out_valid`/`out_pkt` in cycle t+1.
- Throughput: 1 packet/cycle with `out_ready` held high, including drain and grant in the same cycle.
- A requester must hold `req_valid` and `req_pkt` stable until `req_ready`. The arbiter holds `out_pkt` stable while `out_valid && !out_ready`.
- Fairness: a continuously eligible lane is granted within `N_REQ` grants.

## Test plan
- Reset: assert `rst` 2 cycles with all `req_valid=1` → `req_ready=0`, `out_valid=0`, `out_pkt=0`, `issue_cnt=0`. First grant after release is lane 0.
- Single lane: `lane_en=4'hF`, only lane 2 valid with {instr=17'h1ABCD, addr=10'd5}, `out_ready=1` → `req_ready=4'b0100` in cycle t. In t+1: `out_valid=1`, `out_pkt`={17'h1ABCD,10'd5}, `out_src=2`, `issue_cnt=1`.
- Round-robin: all 4 lanes valid continuously, `out_ready=1` → `out_src` sequence 0,1,2,3,0,1 on consecutive cycles. `issue_cnt` increments every cycle.
- Backpressure: FULL with `out_src=1`, then `out_ready=0` for 3 cycles → `out_pkt`/`out_src` stable, `req_ready=0`, `issue_cnt` stable. Raising `out_ready` drains and grants lane 2 in the same cycle.
- Mask: all valid, `lane_en=4'b1010` → grants alternate 1,3,1,3. Lanes 0 and 2 see `req_ready=0` throughout.
- Wrap and reset: 2048 grants → `issue_cnt` returns to 0. Then `rst` during a stall → `out_valid=0` next cycle and the held packet is never issued.

Source files
------------

// File: rtl/instr_arbiter.sv
// Round-robin arbiter feeding a one-entry output register with valid/ready.
// Lanes are searched starting one past the last winner; an issued-packet
// counter wraps modulo 2^CNT_W.

package instr_arbiter_pkg;
  typedef struct packed {
    logic [16:0] instr;
    logic [9:0]  addr;
  } instr_packet_s;
endpackage

module instr_arbiter
  import instr_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  instr_packet_s              req_pkt [N_REQ],
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ-1:0]           lane_en,
  output logic                       out_valid,
  output instr_packet_s              out_pkt,
  output logic [$clog2(N_REQ)-1:0]   out_src,
  input  logic                       out_ready,
  output logic [CNT_W-1:0]           issue_cnt
);

  localparam int SW = $clog2(N_REQ);

  // Output-register occupancy is the only real state.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       state_q, state_d;
  instr_packet_s    pkt_q, pkt_d;
  logic [SW-1:0]    src_q, src_d;
  logic [SW-1:0]    last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_REQ-1:0] eligible;
  logic             load;
  logic             found;
  logic [SW-1:0]    gnt_idx;
  logic             grant_fire;
  int               idx;

  assign eligible = req_valid & lane_en;
  assign load     = (state_q == ST_EMPTY) || out_ready;

  // Rotating search starting one past the previous winner.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_q) + k) % N_REQ;
      if (!found && eligible[idx]) begin
        found   = 1'b1;
        gnt_idx = SW'(idx);
      end
    end
  end

  // No handshake may complete while reset is asserted.
  assign grant_fire = load && found && !rst;

  // One-hot ready toward the winning lane only.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++)
      req_ready[i] = grant_fire && (gnt_idx == SW'(i));
  end

  // Next-state: capture on grant, empty on drain without a winner, else hold.
  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    src_d   = src_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (load) begin
      if (found) begin
        state_d = ST_FULL;
        pkt_d   = req_pkt[gnt_idx];
        src_d   = gnt_idx;
        last_d  = gnt_idx;
        cnt_d   = cnt_q + 1'b1;
      end else begin
        state_d = ST_EMPTY;
      end
    end
  end

  // State registers; last winner resets to the top lane so lane 0 goes first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      pkt_q   <= '0;
      src_q   <= '0;
      last_q  <= SW'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      src_q   <= src_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_pkt   = pkt_q;
  assign out_src   = src_q;
  assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_instr_arbiter.sv
// Self-checking bench for instr_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural round-robin model.

module tb_instr_arbiter;
  import instr_arbiter_pkg::*;

  localparam int N     = 4;
  localparam int CNT_W = 11;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req_valid;
  instr_packet_s       req_pkt [N];
  logic [N-1:0]        req_ready;
  logic [N-1:0]        lane_en;
  logic                out_valid;
  instr_packet_s       out_pkt;
  logic [1:0]          out_src;
  logic                out_ready;
  logic [CNT_W-1:0]    issue_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int            m_last;
  bit            m_valid;
  instr_packet_s m_pkt;
  int            m_src;
  int            m_cnt;

  instr_arbiter #(.N_REQ(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_pkt(req_pkt),
    .req_ready(req_ready), .lane_en(lane_en), .out_valid(out_valid),
    .out_pkt(out_pkt), .out_src(out_src), .out_ready(out_ready),
    .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  // Lane that should win this cycle, or -1 if none / stalled / in reset.
  function automatic int model_grant();
    if (rst) return -1;
    if (m_valid && !out_ready) return -1;
    for (int k = 1; k <= N; k++) begin
      int l;
      l = (m_last + k) % N;
      if (req_valid[l] && lane_en[l]) return l;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    int g;
    g = model_grant();
    return (g >= 0) ? (N'(1) << g) : '0;
  endfunction

  // Advance the model across one clock edge using the pre-edge inputs.
  task automatic model_clock();
    int g;
    g = model_grant();
    if (rst) begin
      m_last = N - 1; m_valid = 0; m_pkt = '0; m_src = 0; m_cnt = 0;
    end else if (!m_valid || out_ready) begin
      if (g >= 0) begin
        m_valid = 1; m_pkt = req_pkt[g]; m_src = g; m_last = g;
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic set_all_pkts();
    for (int l = 0; l < N; l++)
      req_pkt[l] = '{instr: 17'($urandom), addr: 10'($urandom)};
  endtask

  task automatic do_reset();
    rst = 1; req_valid = '0; lane_en = '1; out_ready = 1;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; req_valid = '1; lane_en = '1; out_ready = 1; set_all_pkts();
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if (req_ready !== '0) begin n_err++;
        $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_pkt !== '0) begin n_err++;
      $display("FAIL reset_out_pkt got=%h exp=0", out_pkt); end
    n_cmp++; if (issue_cnt !== '0) begin n_err++;
      $display("FAIL reset_issue_cnt got=%0d exp=0", issue_cnt); end
    rst = 0; #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++;
      $display("FAIL reset_first_grant got=%b exp=0001", req_ready); end
    tick();
  endtask

  task automatic test_single_lane();
    do_reset();
    lane_en = 4'hF; out_ready = 1; req_valid = 4'b0100;
    req_pkt[2] = '{instr: 17'h1ABCD, addr: 10'd5};
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++;
      $display("FAIL single_req_ready got=%b exp=0100", req_ready); end
    tick();
    req_valid = '0;
    n_cmp++; if (out_valid !== 1'b1 || out_src !== 2'd2 || issue_cnt !== 11'd1) begin n_err++;
      $display("FAIL single_out got v=%b src=%0d cnt=%0d exp v=1 src=2 cnt=1",
               out_valid, out_src, issue_cnt); end
    n_cmp++; if (out_pkt !== {17'h1ABCD, 10'd5}) begin n_err++;
      $display("FAIL single_out_pkt got=%h exp=%h", out_pkt, {17'h1ABCD, 10'd5}); end
  endtask

  task automatic test_round_robin();
    int exp_src [6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    req_valid = '1; lane_en = '1; out_ready = 1;
    for (int c = 0; c < 6; c++) begin
      set_all_pkts();
      tick();
      n_cmp++; if (out_src !== 2'(exp_src[c]) || out_valid !== 1'b1) begin n_err++;
        $display("FAIL rr_src[%0d] got=%0d v=%b exp=%0d v=1", c, out_src, out_valid, exp_src[c]); end
      n_cmp++; if (issue_cnt !== CNT_W'(c + 1)) begin n_err++;
        $display("FAIL rr_cnt[%0d] got=%0d exp=%0d", c, issue_cnt, c + 1); end
    end
  endtask

  task automatic test_backpressure();
    instr_packet_s held;
    do_reset();
    req_valid = '1; lane_en = '1; out_ready = 1; set_all_pkts();
    tick(); tick();
    n_cmp++; if (out_src !== 2'd1) begin n_err++;
      $display("FAIL bp_setup_src got=%0d exp=1", out_src); end
    held = out_pkt;
    out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (req_ready !== '0) begin n_err++;
        $display("FAIL bp_req_ready[%0d] got=%b exp=0", c, req_ready); end
      tick();
      n_cmp++; if (out_pkt !== held || out_src !== 2'd1 || issue_cnt !== 11'd2 || out_valid !== 1'b1) begin n_err++;
        $display("FAIL bp_hold[%0d] got pkt=%h src=%0d cnt=%0d exp pkt=%h src=1 cnt=2",
                 c, out_pkt, out_src, issue_cnt, held); end
    end
    out_ready = 1; #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++;
      $display("FAIL bp_release_ready got=%b exp=0100", req_ready); end
    tick();
    n_cmp++; if (out_src !== 2'd2 || out_pkt !== req_pkt[2]) begin n_err++;
      $display("FAIL bp_release_out got src=%0d pkt=%h exp src=2 pkt=%h", out_src, out_pkt, req_pkt[2]); end
  endtask

  task automatic test_mask();
    int exp_src [4] = '{1, 3, 1, 3};
    do_reset();
    req_valid = '1; lane_en = 4'b1010; out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      set_all_pkts(); #1;
      n_cmp++; if (req_ready[0] !== 1'b0 || req_ready[2] !== 1'b0) begin n_err++;
        $display("FAIL mask_ready[%0d] got=%b exp lanes0,2 low", c, req_ready); end
      tick();
      n_cmp++; if (out_src !== 2'(exp_src[c])) begin n_err++;
        $display("FAIL mask_src[%0d] got=%0d exp=%0d", c, out_src, exp_src[c]); end
    end
  endtask

  task automatic test_random();
    int last_g;
    do_reset();
    req_valid = '0; last_g = -1;
    for (int c = 0; c < 400; c++) begin
      for (int l = 0; l < N; l++)
        if (!req_valid[l] || l == last_g) begin
          req_valid[l] = ($urandom % 4) != 0;
          req_pkt[l]   = '{instr: 17'($urandom), addr: 10'($urandom)};
        end
      for (int l = 0; l < N; l++) lane_en[l] = ($urandom % 6) != 0;
      out_ready = ($urandom % 4) != 0;
      #1;
      last_g = model_grant();
      n_cmp++; if (req_ready !== model_ready()) begin n_err++;
        $display("FAIL rand_ready[%0d] got=%b exp=%b", c, req_ready, model_ready()); end
      tick();
      n_cmp++; if (out_valid !== m_valid || out_pkt !== m_pkt || out_src !== 2'(m_src) ||
                   issue_cnt !== CNT_W'(m_cnt)) begin n_err++;
        $display("FAIL rand_out[%0d] got v=%b pkt=%h src=%0d cnt=%0d exp v=%b pkt=%h src=%0d cnt=%0d",
                 c, out_valid, out_pkt, out_src, issue_cnt, m_valid, m_pkt, m_src, m_cnt); end
    end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    req_valid = '1; lane_en = '1; out_ready = 1;
    for (int c = 0; c < 2048; c++) tick();
    n_cmp++; if (issue_cnt !== '0 || out_valid !== 1'b1) begin n_err++;
      $display("FAIL wrap_cnt got=%0d v=%b exp=0 v=1", issue_cnt, out_valid); end
    out_ready = 0; tick();
    rst = 1; #1;
    n_cmp++; if (req_ready !== '0) begin n_err++;
      $display("FAIL wrap_rst_ready got=%b exp=0", req_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++;
      $display("FAIL wrap_rst_valid got=%b exp=0", out_valid); end
    rst = 0; req_valid = '0; out_ready = 1;
    tick();
    n_cmp++; if (out_valid !== 1'b0 || issue_cnt !== '0) begin n_err++;
      $display("FAIL wrap_discard got v=%b cnt=%0d exp v=0 cnt=0", out_valid, issue_cnt); end
  endtask

  initial begin
    rst = 1; req_valid = '0; lane_en = '0; out_ready = 0;
    for (int l = 0; l < N; l++) req_pkt[l] = '0;
    m_last = N - 1; m_valid = 0; m_pkt = '0; m_src = 0; m_cnt = 0;
    test_reset();
    test_single_lane();
    test_round_robin();
    test_backpressure();
    test_mask();
    test_random();
    test_wrap_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
